// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares a single fifo write port
// among NUM_REQ valid/ready producers. A producer wins in IDLE (one-cycle
// arbitration bubble), then owns the port in BURST for up to MAX_BURST
// accepted words. The data path is a zero-latency combinational owner mux.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_BURST = 1'b1;

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W:0]    NUM_EXT  = (ID_W + 1)'(NUM_REQ);

  // Architectural state
  logic [0:0]       state_q,     state_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]  owner_q,     owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // Combinational helpers
  logic                  owner_valid_s;
  logic [DATA_WIDTH-1:0] owner_data_s;
  logic                  any_valid_s;
  logic [ID_W-1:0]       winner_s;
  logic                  in_burst_s;
  logic                  port_open_s;
  logic                  transfer_s;
  logic                  last_word_s;
  logic                  release_s;
  logic [ID_W-1:0]       next_ptr_s;

  // Select the current owner's valid bit and data word.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_data_s  = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        owner_valid_s = req_valid[i];
        owner_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        owner_valid_s = owner_valid_s;
        owner_data_s  = owner_data_s;
      end
    end
  end

  // Round-robin search: first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  // Walking the offsets downward lets the smallest offset overwrite last.
  always_comb begin
    logic [ID_W:0] cand;
    any_valid_s = |req_valid;
    winner_s    = rr_ptr_q;
    cand        = {(ID_W + 1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end else begin
        cand = cand;
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        winner_s = cand[ID_W-1:0];
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Port handshake qualifiers; everything is gated off while reset is held.
  always_comb begin
    in_burst_s  = rst_n && (state_q == ST_BURST);
    port_open_s = in_burst_s && !fifo_full;
    transfer_s  = port_open_s && owner_valid_s;
    last_word_s = transfer_s && (burst_cnt_q == LAST_CNT);
    release_s   = in_burst_s && (last_word_s || !owner_valid_s);
    if (owner_q == LAST_ID) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = owner_q + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Drive the one-hot (or zero) ready vector and the fifo write port.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        req_ready[i] = port_open_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
    fifo_wr_en = transfer_s;
    fifo_wdata = owner_data_s;
    grant_id   = owner_q;
    busy       = in_burst_s;
  end

  // Next-state logic for the IDLE/BURST controller and its counters.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          owner_d     = winner_s;
          burst_cnt_d = {CNT_W{1'b0}};
          state_d     = ST_BURST;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (transfer_s) begin
          burst_cnt_d = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        if (release_s) begin
          // Counter is cleared so it never rests above MAX_BURST-1.
          state_d     = ST_IDLE;
          burst_cnt_d = {CNT_W{1'b0}};
          rr_ptr_d    = next_ptr_s;
        end else begin
          state_d     = ST_BURST;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {ID_W{1'b0}};
      owner_q     <= {ID_W{1'b0}};
      burst_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected {grant_id, word} pairs are
// queued when the stimulus is set up and popped on every observed fifo write.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic        b_rst_n;
  logic [1:0]  b_valid;
  logic [15:0] b_data;
  logic [1:0]  b_ready;
  logic        b_wr_en;
  logic [7:0]  b_wdata;
  logic        b_full;
  logic [0:0]  b_grant;
  logic        b_busy;

  logic [7:0]  seq [4];
  logic [7:0]  exp_seq [4];
  logic [9:0]  exp_q [$];
  logic [7:0]  b_seq [2];
  logic [8:0]  b_q [$];
  int          b_fcount;
  int          checks;
  int          errors;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy));

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .fifo_wr_en(b_wr_en), .fifo_wdata(b_wdata),
    .fifo_full(b_full), .grant_id(b_grant), .busy(b_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Producer words: producer i presents base_i + number of words it has had accepted.
  always_comb begin
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i * 16) + seq[i];
    for (int i = 0; i < 2; i++) b_data[i*8 +: 8] = 8'h50 + 8'(i * 16) + b_seq[i];
  end

  task automatic push_words(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({2'(id), 8'hA0 + 8'(id * 16) + exp_seq[id]});
      exp_seq[id] = exp_seq[id] + 8'd1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin seq[i] = 8'd0; exp_seq[i] = 8'd0; end
    exp_q.delete();
  endtask

  // One cycle of dut_a: sample at negedge, pop the scoreboard on a write, advance producers.
  task automatic tick(input logic chk, input logic exp_wr, input logic exp_busy);
    logic [3:0] acc;
    logic [9:0] exp;
    @(negedge clk);
    checks++;
    if (fifo_full && (fifo_wr_en || req_ready != 4'b0000)) begin
      errors++; $display("FAIL full_block: wr_en=%b ready=%b while full", fifo_wr_en, req_ready);
    end
    checks++;
    if ((req_ready & (req_ready - 4'd1)) != 4'b0000) begin
      errors++; $display("FAIL ready_onehot: ready=%b, required one-hot or zero", req_ready);
    end
    if (!rst_n) begin
      checks++;
      if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_force: ready=%b wr=%b busy=%b, required all 0", req_ready, fifo_wr_en, busy);
      end
    end
    if (chk) begin
      checks++;
      if (fifo_wr_en !== exp_wr) begin
        errors++; $display("FAIL wr_en_timing @%0t: got %b, expected %b", $time, fifo_wr_en, exp_wr);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy_timing @%0t: got %b, expected %b", $time, busy, exp_busy);
      end
    end
    if (fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_write: id=%0d data=%h with empty scoreboard", grant_id, fifo_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({grant_id, fifo_wdata} !== exp) begin
          errors++; $display("FAIL write_word: got id=%0d data=%h, expected id=%0d data=%h",
                             grant_id, fifo_wdata, exp[9:8], exp[7:0]);
        end
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (acc[i]) seq[i] = seq[i] + 8'd1;
  endtask

  // One cycle of dut_b with a depth-16 fifo model driving b_full.
  task automatic tick_b();
    logic [1:0] acc;
    logic [8:0] exp;
    @(negedge clk);
    checks++;
    if (b_full && (b_wr_en || b_ready != 2'b00)) begin
      errors++; $display("FAIL b_full_block: wr_en=%b ready=%b while full", b_wr_en, b_ready);
    end
    if (b_wr_en === 1'b1) begin
      checks++;
      b_fcount++;
      if (b_q.size() == 0) begin
        errors++; $display("FAIL b_unexpected_write: id=%0d data=%h", b_grant, b_wdata);
      end else begin
        exp = b_q.pop_front();
        if ({b_grant, b_wdata} !== exp) begin
          errors++; $display("FAIL b_write_word: got id=%0d data=%h, expected id=%0d data=%h",
                             b_grant, b_wdata, exp[8], exp[7:0]);
        end
      end
    end
    acc = b_valid & b_ready;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) if (acc[i]) b_seq[i] = b_seq[i] + 8'd1;
    b_full = (b_fcount >= 16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_state: ready=%b wr=%b busy=%b grant=%0d, required 0/0/0/0",
                         req_ready, fifo_wr_en, busy, grant_id);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b grant=%0d, required 0/0", busy, grant_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001;
    push_words(0, 8);
    for (int r = 0; r < 2; r++) begin
      tick(1'b1, 1'b0, 1'b0);
      repeat (4) tick(1'b1, 1'b1, 1'b1);
    end
    req_valid = 4'b0000;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: %0d words missing", exp_q.size()); end
  endtask

  task automatic test_all_valid();
    apply_reset();
    req_valid = 4'b1111;
    push_words(0, 4); push_words(1, 4); push_words(2, 4); push_words(3, 4); push_words(0, 4);
    for (int b = 0; b < 5; b++) begin
      tick(1'b1, 1'b0, 1'b0);
      repeat (4) tick(1'b1, 1'b1, 1'b1);
    end
    req_valid = 4'b0000;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rotate_drain: %0d words missing", exp_q.size()); end
  endtask

  task automatic test_full_stall();
    apply_reset();
    req_valid = 4'b0100;
    push_words(2, 4);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    fifo_full = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    fifo_full = 1'b0;
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    req_valid = 4'b0000;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d words missing", exp_q.size()); end
  endtask

  task automatic test_drop_valid();
    apply_reset();
    req_valid = 4'b0010;
    push_words(1, 2);
    push_words(3, 4);
    tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    req_valid = 4'b1001;
    tick(1'b1, 1'b0, 1'b1);
    req_valid = 4'b1011;
    tick(1'b1, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 1'b1);
    req_valid = 4'b0000;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_drain: %0d words missing", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid = 4'b1000;
    push_words(3, 2);
    tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL mid_reset_state: busy=%b grant=%0d, required 0/0", busy, grant_id);
    end
    push_words(1, 4);
    tick(1'b1, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 1'b1);
    req_valid = 4'b0000;
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || seq[3] !== 8'd2) begin
      errors++; $display("FAIL mid_reset_drain: left=%0d p3_accepted=%0d, required 0/2", exp_q.size(), seq[3]);
    end
  endtask

  task automatic test_burst1();
    int cyc;
    b_rst_n = 1'b0;
    b_valid = 2'b00;
    b_full = 1'b0;
    b_fcount = 0;
    b_seq[0] = 8'd0; b_seq[1] = 8'd0;
    repeat (2) begin @(posedge clk); #1; end
    b_rst_n = 1'b1;
    b_valid = 2'b11;
    for (int k = 0; k < 16; k++) b_q.push_back({1'(k % 2), 8'h50 + 8'((k % 2) * 16) + 8'(k / 2)});
    cyc = 0;
    while (b_fcount < 16 && cyc < 64) begin tick_b(); cyc++; end
    checks++;
    if (b_fcount != 16 || b_q.size() != 0) begin
      errors++; $display("FAIL b_fill: wrote %0d words, left %0d, required 16/0", b_fcount, b_q.size());
    end
    repeat (6) tick_b();
    checks++;
    if (b_fcount != 16 || b_full !== 1'b1) begin
      errors++; $display("FAIL b_full_stall: count=%0d full=%b, required 16/1", b_fcount, b_full);
    end
    b_valid = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin seq[i] = 8'd0; exp_seq[i] = 8'd0; end
    b_rst_n = 1'b0;
    b_valid = 2'b00;
    b_full = 1'b0;
    b_fcount = 0;
    b_seq[0] = 8'd0; b_seq[1] = 8'd0;

    test_reset();
    test_single();
    test_all_valid();
    test_full_stall();
    test_drop_valid();
    test_reset_mid_burst();
    test_burst1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
